// File: rtl/i2c_master_bit_ctrl_pkg.sv
// Shared types for the I2C bit-level master: command codes, FSM states and the per-phase line table.
package i2c_pkg;

  localparam int CLK_DIV_MIN = 4;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4,
    RESP = 3'd5
  } state_e;

  // Open-drain enables: 1 pulls the line low.
  typedef struct packed {
    logic scl;
    logic sda;
  } drive_t;

  // Line drive for a given state; outside the four phases the held idle levels apply.
  function automatic drive_t phase_drive(state_e st, cmd_e c, logic wr, drive_t held);
    drive_t d;
    d = held;
    case (st)
      PH_A: case (c)
        CMD_START: d = '{scl: held.scl, sda: 1'b0};
        CMD_STOP:  d = '{scl: 1'b1, sda: 1'b1};
        CMD_WRITE: d = '{scl: 1'b1, sda: ~wr};
        CMD_READ:  d = '{scl: 1'b1, sda: 1'b0};
      endcase
      PH_B: case (c)
        CMD_START: d = '{scl: 1'b0, sda: 1'b0};
        CMD_STOP:  d = '{scl: 1'b0, sda: 1'b1};
        CMD_WRITE: d = '{scl: 1'b0, sda: ~wr};
        CMD_READ:  d = '{scl: 1'b0, sda: 1'b0};
      endcase
      PH_C: case (c)
        CMD_START: d = '{scl: 1'b0, sda: 1'b1};
        CMD_STOP:  d = '{scl: 1'b0, sda: 1'b0};
        CMD_WRITE: d = '{scl: 1'b0, sda: ~wr};
        CMD_READ:  d = '{scl: 1'b0, sda: 1'b0};
      endcase
      PH_D: case (c)
        CMD_START: d = '{scl: 1'b1, sda: 1'b1};
        CMD_STOP:  d = '{scl: 1'b0, sda: 1'b0};
        CMD_WRITE: d = '{scl: 1'b1, sda: ~wr};
        CMD_READ:  d = '{scl: 1'b1, sda: 1'b0};
      endcase
      default: d = held;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_master_bit_ctrl_if.sv
// Command/response handshake between the byte-level master FSM and the bit engine.
interface i2c_master_bit_ctrl_if;
  import i2c_pkg::*;

  logic cmd_valid;
  logic cmd_ready;
  cmd_e cmd;
  logic wr_bit;
  logic rsp_valid;
  logic rsp_bit;
  logic arb_lost;
  logic cmd_err;
  logic bus_owned;

  modport master (
    output cmd_valid, cmd, wr_bit,
    input  cmd_ready, rsp_valid, rsp_bit, arb_lost, cmd_err, bus_owned
  );

  modport slave (
    input  cmd_valid, cmd, wr_bit,
    output cmd_ready, rsp_valid, rsp_bit, arb_lost, cmd_err, bus_owned
  );
endinterface

// File: rtl/i2c_master_bit_ctrl_sync2.sv
// Two-flop synchronizer for an asynchronous pad input, with selectable reset level.
module i2c_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/i2c_master_bit_ctrl.sv
// I2C bit-level master: START/STOP/WRITE/READ in four CLK_DIV-long phases, open-drain SCL/SDA.
// Optional macro I2C_CLK_STRETCH_EN lets a slave stretch SCL during phase B.
module i2c_master_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_master_bit_ctrl_if.slave  ctl,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  scl_oe,
  output logic                  sda_oe
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  cmd_e             cmd_q, cmd_d;
  logic             wr_q, wr_d;
  drive_t           hold, hold_d, drv_d;
  logic             owned, owned_d;
  logic             sda_smp, sda_smp_d;
  logic             rbit_q, rbit_d, arb_q, arb_d, err_q, err_d;
  logic             scl_s, sda_s, stall, last;

  i2c_sync2 #(.RST_VAL(1'b1)) u_sync_scl (.clk(clk), .rst(rst), .d(scl_in), .q(scl_s));
  i2c_sync2 #(.RST_VAL(1'b1)) u_sync_sda (.clk(clk), .rst(rst), .d(sda_in), .q(sda_s));

`ifdef I2C_CLK_STRETCH_EN
  // Phase B waits at count 0 while a slave holds SCL low.
  assign stall = (state == PH_B) && (cnt == '0) && !scl_s;
`else
  logic unused_scl_s;
  assign unused_scl_s = scl_s;
  assign stall        = 1'b0;
`endif

  assign last = (cnt == CNT_LAST);

  // NOTE: every combinationally written signal gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cmd_d     = cmd_q;
    wr_d      = wr_q;
    hold_d    = hold;
    owned_d   = owned;
    sda_smp_d = sda_smp;
    rbit_d    = 1'b0;
    arb_d     = 1'b0;
    err_d     = 1'b0;
    case (state)
      IDLE: if (ctl.cmd_valid) begin
        cmd_d = ctl.cmd;
        wr_d  = ctl.wr_bit;
        cnt_d = '0;
        if ((ctl.cmd == CMD_WRITE || ctl.cmd == CMD_READ) && !owned) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          state_d = PH_A;
        end
      end
      PH_A, PH_B, PH_C: begin
        if (stall) begin
          cnt_d = '0;
        end else if (!last) begin
          cnt_d = cnt + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (state == PH_A) state_d = PH_B;
          else if (state == PH_B) state_d = PH_C;
          else begin
            sda_smp_d = sda_s;
            // A released SDA read back low means another master won the bit.
            if (cmd_q == CMD_WRITE && wr_q && !sda_s) begin
              state_d = RESP;
              arb_d   = 1'b1;
              owned_d = 1'b0;
              hold_d  = '{scl: 1'b0, sda: 1'b0};
            end else begin
              state_d = PH_D;
            end
          end
        end
      end
      PH_D: begin
        if (!last) begin
          cnt_d = cnt + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = RESP;
          hold_d  = phase_drive(PH_D, cmd_q, wr_q, hold);
          rbit_d  = (cmd_q == CMD_READ) && sda_smp;
          if (cmd_q == CMD_START) owned_d = 1'b1;
          if (cmd_q == CMD_STOP)  owned_d = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line enables are registered from next-state values so the pads never see decode glitches.
  assign drv_d = phase_drive(state_d, cmd_d, wr_d, hold_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cmd_q   <= CMD_START;
      wr_q    <= 1'b0;
      hold    <= '{scl: 1'b0, sda: 1'b0};
      owned   <= 1'b0;
      sda_smp <= 1'b0;
      rbit_q  <= 1'b0;
      arb_q   <= 1'b0;
      err_q   <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cmd_q   <= cmd_d;
      wr_q    <= wr_d;
      hold    <= hold_d;
      owned   <= owned_d;
      sda_smp <= sda_smp_d;
      rbit_q  <= rbit_d;
      arb_q   <= arb_d;
      err_q   <= err_d;
      scl_oe  <= drv_d.scl;
      sda_oe  <= drv_d.sda;
    end
  end

  assign ctl.cmd_ready = (state == IDLE);
  assign ctl.rsp_valid = (state == RESP);
  assign ctl.rsp_bit   = rbit_q;
  assign ctl.arb_lost  = arb_q;
  assign ctl.cmd_err   = err_q;
  assign ctl.bus_owned = owned;
endmodule

// File: tb/tb_i2c_master_bit_ctrl.sv
// Self-checking bench for i2c_master_bit_ctrl: directed plan steps plus randomized commands
// against a command-level model of the bus (ownership, idle line levels, expected phase patterns).
module tb_i2c_master_bit_ctrl;
  import i2c_pkg::*;

  localparam int CD = 4;

  logic clk = 1'b0;
  logic rst;
  logic scl_in, sda_in, scl_oe, sda_oe;
  logic slave_sda_low, slave_scl_low, scl_wired;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Command-level model state.
  logic m_owned, m_scl, m_sda;

  i2c_master_bit_ctrl_if bus ();

  i2c_master_bit_ctrl #(.CLK_DIV(CD), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .ctl    (bus),
    .scl_in (scl_in),
    .sda_in (sda_in),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe)
  );

  // Wired-AND bus: master and slave can each pull a line low.
  assign sda_in = ~sda_oe & ~slave_sda_low;
  assign scl_in = ~(scl_wired & scl_oe) & ~slave_scl_low;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input cmd_e c, input logic w, input logic slave_low, input string tag);
    logic exp_scl[4];
    logic exp_sda[4];
    logic nx_owned, nx_scl, nx_sda, e_err, e_arb, e_bit;
    int   exp_lat, seen, waited;
    e_err   = (c == CMD_WRITE || c == CMD_READ) && !m_owned;
    e_arb   = !e_err && c == CMD_WRITE && w && slave_low;
    e_bit   = !e_err && c == CMD_READ && !slave_low;
    exp_lat = e_err ? 1 : (e_arb ? 3*CD + 1 : 4*CD + 1);
    case (c)
      CMD_START: begin
        exp_scl = '{m_scl, 1'b0, 1'b0, 1'b1}; exp_sda = '{1'b0, 1'b0, 1'b1, 1'b1};
        nx_owned = 1'b1; nx_scl = 1'b1; nx_sda = 1'b1;
      end
      CMD_STOP: begin
        exp_scl = '{1'b1, 1'b0, 1'b0, 1'b0}; exp_sda = '{1'b1, 1'b1, 1'b0, 1'b0};
        nx_owned = 1'b0; nx_scl = 1'b0; nx_sda = 1'b0;
      end
      CMD_WRITE: begin
        exp_scl = '{1'b1, 1'b0, 1'b0, 1'b1}; exp_sda = '{~w, ~w, ~w, ~w};
        nx_owned = m_owned; nx_scl = 1'b1; nx_sda = ~w;
      end
      default: begin
        exp_scl = '{1'b1, 1'b0, 1'b0, 1'b1}; exp_sda = '{1'b0, 1'b0, 1'b0, 1'b0};
        nx_owned = m_owned; nx_scl = 1'b1; nx_sda = 1'b0;
      end
    endcase
    if (e_err) begin
      nx_owned = m_owned; nx_scl = m_scl; nx_sda = m_sda;
    end
    if (e_arb) begin
      nx_owned = 1'b0; nx_scl = 1'b0; nx_sda = 1'b0;
    end

    slave_sda_low = slave_low;
    waited = 0;
    while (!bus.cmd_ready && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, " ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.wr_bit    = w;
    tick();
    bus.cmd_valid = 1'b0;

    seen = 0;
    for (int n = 1; n <= exp_lat + 4; n++) begin
      if (bus.rsp_valid) begin
        seen = n;
        break;
      end
      if (n < exp_lat) begin
        check($sformatf("%s scl c%0d", tag, n), scl_oe, exp_scl[(n-1)/CD]);
        check($sformatf("%s sda c%0d", tag, n), sda_oe, exp_sda[(n-1)/CD]);
      end
      tick();
    end
    check({tag, " latency"}, seen, exp_lat);
    check({tag, " rsp_bit"}, bus.rsp_bit, e_bit);
    check({tag, " arb_lost"}, bus.arb_lost, e_arb);
    check({tag, " cmd_err"}, bus.cmd_err, e_err);
    check({tag, " ready in rsp"}, bus.cmd_ready, 0);
    check({tag, " owned"}, bus.bus_owned, nx_owned);
    check({tag, " scl rsp"}, scl_oe, nx_scl);
    check({tag, " sda rsp"}, sda_oe, nx_sda);
    tick();
    check({tag, " rsp drop"}, bus.rsp_valid, 0);
    check({tag, " flags idle"}, {bus.rsp_bit, bus.arb_lost, bus.cmd_err}, 0);
    check({tag, " ready idle"}, bus.cmd_ready, 1);
    check({tag, " scl idle"}, scl_oe, nx_scl);
    check({tag, " sda idle"}, sda_oe, nx_sda);
    m_owned = nx_owned; m_scl = nx_scl; m_sda = nx_sda;
    slave_sda_low = 1'b0;
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic measure_write(input int stretch, output int lat);
    bus.cmd_valid = 1'b1;
    bus.cmd       = CMD_WRITE;
    bus.wr_bit    = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8*CD + stretch + 20; n++) begin
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
      if (n == CD + 1 && stretch > 0) slave_scl_low = 1'b1;
      if (n == CD + 1 + stretch) slave_scl_low = 1'b0;
      tick();
    end
    slave_scl_low = 1'b0;
    tick();
  endtask
`endif

  initial begin
    int rsp_seen;
`ifdef I2C_CLK_STRETCH_EN
    int lat_base, lat_str;
`endif
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd = CMD_START;
    bus.wr_bit = 1'b0;
    slave_sda_low = 1'b0;
    slave_scl_low = 1'b0;
    scl_wired = 1'b0;
    m_owned = 1'b0; m_scl = 1'b0; m_sda = 1'b0;

    repeat (3) tick();
    check("reset scl_oe", scl_oe, 0);
    check("reset sda_oe", sda_oe, 0);
    check("reset ready", bus.cmd_ready, 1);
    check("reset rsp", {bus.rsp_valid, bus.rsp_bit, bus.arb_lost, bus.cmd_err}, 0);
    check("reset owned", bus.bus_owned, 0);
    rst = 1'b0;
    tick();

    // Directed plan.
    run_cmd(CMD_READ,  1'b0, 1'b0, "read no bus");
    run_cmd(CMD_START, 1'b0, 1'b0, "start idle");
    run_cmd(CMD_WRITE, 1'b0, 1'b0, "write0");
    run_cmd(CMD_READ,  1'b0, 1'b1, "read low");
    run_cmd(CMD_READ,  1'b0, 1'b0, "read high");
    run_cmd(CMD_START, 1'b0, 1'b0, "restart");
    run_cmd(CMD_WRITE, 1'b1, 1'b1, "arb lost");
    run_cmd(CMD_WRITE, 1'b1, 1'b0, "write no bus");
    run_cmd(CMD_START, 1'b0, 1'b0, "start2");
    run_cmd(CMD_WRITE, 1'b1, 1'b0, "write1");
    run_cmd(CMD_STOP,  1'b0, 1'b0, "stop");
    run_cmd(CMD_STOP,  1'b0, 1'b0, "stop unowned");

    // Randomized command stream.
    for (int i = 0; i < 40; i++) begin
      run_cmd(cmd_e'($urandom_range(0, 3)), 1'($urandom % 2), 1'($urandom % 2),
              $sformatf("rnd%0d", i));
    end

`ifdef I2C_CLK_STRETCH_EN
    run_cmd(CMD_START, 1'b0, 1'b0, "stretch start");
    scl_wired = 1'b1;
    measure_write(0, lat_base);
    measure_write(20, lat_str);
    scl_wired = 1'b0;
    check("stretch base seen", lat_base != 0, 1);
    check("stretch delta", lat_str - lat_base, 20);
`endif

    // Reset in the middle of phase C of a START.
    bus.cmd_valid = 1'b1;
    bus.cmd = CMD_START;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (2*CD + 1) tick();
    check("midC sda_oe", sda_oe, 1);
    check("midC scl_oe", scl_oe, 0);
    rst = 1'b1;
    tick();
    check("rst scl_oe", scl_oe, 0);
    check("rst sda_oe", sda_oe, 0);
    check("rst owned", bus.bus_owned, 0);
    check("rst ready", bus.cmd_ready, 1);
    rst = 1'b0;
    rsp_seen = 0;
    for (int n = 0; n < 4*CD + 4; n++) begin
      if (bus.rsp_valid) rsp_seen++;
      tick();
    end
    check("rst no rsp", rsp_seen, 0);
    m_owned = 1'b0; m_scl = 1'b0; m_sda = 1'b0;
    run_cmd(CMD_START, 1'b0, 1'b0, "post rst start");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_master_bit_ctrl.md
Name: i2c_master_bit_ctrl

Overview:
Bit-level I2C master engine that generates the bus conditions the slave side detects: START, repeated START, STOP, and single data bits (write or read).
- Takes one command per handshake and drives SCL/SDA as open-drain enables, four timed phases per command.
- Samples SDA for read data and arbitration.
- Sits below a byte-level master FSM and above the pad open-drain buffers.

Parameters:
CLK_DIV, 250, clk cycles per quarter SCL period (100 kHz at 100 MHz clk); legal range 4..65535
CNT_W, 16, width of the phase counter; must hold CLK_DIV-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high when engine is IDLE and can accept a command
cmd  input  2  00 START, 01 STOP, 10 WRITE, 11 READ
wr_bit  input  1  data bit for WRITE, sampled with the command
rsp_valid  output  1  one-cycle pulse when a command completes
rsp_bit  output  1  SDA value sampled for READ (0 for other commands)
arb_lost  output  1  qualifies rsp_valid: arbitration lost on WRITE
cmd_err  output  1  qualifies rsp_valid: WRITE/READ issued without bus ownership
bus_owned  output  1  high from a completed START until STOP completes or arbitration is lost
scl_in  input  1  SCL pad input (async)
sda_in  input  1  SDA pad input (async)
scl_oe  output  1  1 = pull SCL low, 0 = release
sda_oe  output  1  1 = pull SDA low, 0 = release

Behaviour:
- Reset: state IDLE, counter 0, scl_oe=0, sda_oe=0, rsp_valid=0, rsp_bit=0, arb_lost=0, cmd_err=0, bus_owned=0, cmd_ready=1. Synchronizer flops reset to 1.
- Reset mid-command: lines are released on the next edge, with no completion pulse. Any resulting spurious bus condition is accepted.
- sda_in and scl_in pass through 2-flop synchronizers (reset value 1). All sampling uses the synchronized values.
- Handshake:
  - A command is accepted on the cycle where cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE, and it is 0 in the cycle rsp_valid is high.
  - cmd and wr_bit are registered at acceptance.
- Phasing:
  - Each command runs phases A, B, C, D, each exactly CLK_DIV cycles (counter 0..CLK_DIV-1).
  - Phase A starts the cycle after acceptance.
  - rsp_valid pulses in the cycle after phase D ends, as the engine returns to IDLE.
  - Total latency from acceptance to rsp_valid is 4*CLK_DIV+1 cycles.
- Line drive per phase (scl_oe / sda_oe):
  - START: A 0-or-held / 0. SCL stays as it was, so an idle bus stays released; a repeated START keeps SCL low.
  - START: B 0/0, C 0/1 (the START edge), D 1/1. Sets bus_owned at completion.
  - STOP: A 1/1, B 0/1, C 0/0 (the STOP edge), D 0/0. Clears bus_owned at completion.
  - WRITE: A 1/~wr_bit, B 0/~wr_bit, C 0/~wr_bit, D 1/~wr_bit.
  - READ: A 1/0, B 0/0, C 0/0, D 1/0.
  - After START, WRITE or READ, scl_oe stays 1 in IDLE. After STOP, both lines stay 0.
- READ: rsp_bit = synced SDA sampled on the last cycle of phase C.
- Arbitration: on a WRITE with wr_bit=1, synced SDA=0 on the last cycle of phase C means arbitration is lost.
  - Next cycle: scl_oe=0, sda_oe=0, bus_owned=0, rsp_valid=1, arb_lost=1. Phase D is skipped.
- WRITE or READ with bus_owned=0:
  - No line activity.
  - rsp_valid=1 and cmd_err=1 in the cycle after acceptance.
- START with bus_owned=1 is a repeated START and is legal. STOP with bus_owned=0 is executed normally.
- rsp_bit, arb_lost and cmd_err are valid only while rsp_valid=1 and are 0 otherwise.

Optional Feature:
I2C_CLK_STRETCH_EN
- Defined: in phase B of every command, the counter holds at 0 until synced SCL reads 1. This allows slave clock stretching, and phase B length becomes CLK_DIV plus the stretch time.
- Undefined: scl_in is ignored and phase B is always CLK_DIV cycles.

Decomposition:
- Package i2c_pkg holds:
  - cmd encodings CMD_START, CMD_STOP, CMD_WRITE, CMD_READ
  - state enum IDLE, PH_A, PH_B, PH_C, PH_D, RESP
  - localparam for minimum CLK_DIV
- One sub-module: i2c_sync2, a 2-flop synchronizer with parameterized reset value, instantiated for SDA and SCL.

Test Plan:
- CLK_DIV=4, idle bus, START accepted at cycle T:
  - sda_oe rises at T+9
  - scl_oe rises at T+13
  - rsp_valid at T+17, bus_owned=1 afterwards
- After START, WRITE wr_bit=0: sda_oe=1 for all phases, scl_oe pattern 1,0,0,1 per phase, rsp_valid with arb_lost=0 after 17 cycles.
- After START, READ with sda_in driven 0 during phase C: rsp_valid with rsp_bit=0. Repeat with sda_in=1: rsp_bit=1.
- After START, WRITE wr_bit=1 with sda_in forced 0: rsp_valid and arb_lost=1 one cycle after phase C; scl_oe=0, sda_oe=0, bus_owned=0.
- From reset, READ command: rsp_valid with cmd_err=1 one cycle after acceptance, scl_oe and sda_oe stay 0. Then STOP after a START: both lines released, bus_owned=0.
- I2C_CLK_STRETCH_EN defined, scl_in held low 20 cycles into phase B of a WRITE: rsp_valid arrives 20 cycles later than nominal. A reset asserted mid-phase C releases both lines on the next edge with no rsp_valid.
